// File: rtl/core_pkg.sv
// Shared encodings and types for the single-cycle 16-bit core.
package core_pkg;

    // Major opcode, inst[15:14]
    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ALU = 2'b11;

    // ALU function, inst[7:4]
    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_SUB = 4'd1;
    localparam logic [3:0] F_AND = 4'd2;
    localparam logic [3:0] F_OR  = 4'd3;
    localparam logic [3:0] F_XOR = 4'd4;
    localparam logic [3:0] F_CMP = 4'd5;
    localparam logic [3:0] F_MOV = 4'd6;
    localparam logic [3:0] F_SLL = 4'd8;
    localparam logic [3:0] F_SLR = 4'd9;
    localparam logic [3:0] F_SRL = 4'd10;
    localparam logic [3:0] F_SRA = 4'd11;
    localparam logic [3:0] F_IN  = 4'd12;
    localparam logic [3:0] F_OUT = 4'd13;
    localparam logic [3:0] F_HLT = 4'd15;

    // op=10 sub-opcode, inst[13:11]
    localparam logic [2:0] BR_LI  = 3'b000;
    localparam logic [2:0] BR_B   = 3'b100;
    localparam logic [2:0] BR_BCC = 3'b111;

    // Branch condition, inst[10:8]
    localparam logic [2:0] CC_BE  = 3'd0;
    localparam logic [2:0] CC_BLT = 3'd1;
    localparam logic [2:0] CC_BLE = 3'd2;
    localparam logic [2:0] CC_BNE = 3'd3;

    typedef struct packed {
        logic s;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic [15:0] sext8(input logic [7:0] x);
        return {{8{x[7]}}, x};
    endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU: computes result, flags, and whether rd / flags are updated.
module alu
    import core_pkg::*;
(
    input  logic [15:0] a_i,       // rd value
    input  logic [15:0] b_i,       // rs value
    input  logic [15:0] in_dat_i,
    input  logic [3:0]  f_i,
    input  logic [3:0]  d_i,
    output logic [15:0] res_o,
    output flags_t      flags_o,
    output logic        wr_o,      // result goes to rd
    output logic        upd_o      // flags take the new value
);

    logic [16:0] tmp;
    logic        c;
    logic        v;

    // Function select; carry is the extra bit of a 17-bit intermediate
    always_comb begin
        tmp   = '0;
        res_o = a_i;
        c     = 1'b0;
        v     = 1'b0;
        wr_o  = 1'b0;
        upd_o = 1'b0;
        case (f_i)
            F_ADD: begin
                tmp   = {1'b0, a_i} + {1'b0, b_i};
                res_o = tmp[15:0];
                c     = tmp[16];
                v     = (a_i[15] == b_i[15]) && (res_o[15] != a_i[15]);
                wr_o  = 1'b1;
                upd_o = 1'b1;
            end
            F_SUB, F_CMP: begin
                tmp   = {1'b0, a_i} - {1'b0, b_i};
                res_o = tmp[15:0];
                c     = tmp[16];               // borrow
                v     = (a_i[15] != b_i[15]) && (res_o[15] != a_i[15]);
                wr_o  = (f_i == F_SUB);
                upd_o = 1'b1;
            end
            F_AND: begin res_o = a_i & b_i; wr_o = 1'b1; upd_o = 1'b1; end
            F_OR:  begin res_o = a_i | b_i; wr_o = 1'b1; upd_o = 1'b1; end
            F_XOR: begin res_o = a_i ^ b_i; wr_o = 1'b1; upd_o = 1'b1; end
            F_MOV: begin res_o = b_i;       wr_o = 1'b1; upd_o = 1'b1; end
            F_IN:  begin res_o = in_dat_i;  wr_o = 1'b1; upd_o = 1'b1; end
            F_SLL: begin
                tmp   = {1'b0, a_i} << d_i;
                res_o = tmp[15:0];
                c     = tmp[16];
                wr_o  = 1'b1;
                upd_o = 1'b1;
            end
            F_SLR: begin
                res_o = (a_i << d_i) | (a_i >> (5'd16 - {1'b0, d_i}));
                // last bit rotated out of the top lands in bit 0
                c     = (d_i != 4'd0) & res_o[0];
                wr_o  = 1'b1;
                upd_o = 1'b1;
            end
            F_SRL: begin
                tmp   = {a_i, 1'b0} >> d_i;
                res_o = tmp[16:1];
                c     = tmp[0];
                wr_o  = 1'b1;
                upd_o = 1'b1;
            end
            F_SRA: begin
                tmp   = $signed({a_i, 1'b0}) >>> d_i;
                res_o = tmp[16:1];
                c     = tmp[0];
                wr_o  = 1'b1;
                upd_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign flags_o = '{s: res_o[15], z: (res_o == 16'd0), c: c, v: v};

endmodule

// File: rtl/core.sv
// Single-cycle 16-bit core: fetch, execute and writeback in one clock.
module core
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] inst_mem_adr,
    input  logic [15:0] inst,
    output logic [15:0] main_mem_read_adr,
    input  logic [15:0] main_mem_dat,
    output logic        main_mem_write,
    output logic [15:0] main_mem_write_adr,
    output logic [15:0] main_mem_write_dat,
    input  logic [15:0] in_dat,
    output logic        out_en,
    output logic [15:0] out_dat,
    output logic        is_halt
);

    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [15:0] pc_q, pc_d;
    flags_t      flags_q, flags_d;
    logic [15:0] out_dat_q, out_dat_d;
    logic        out_en_q, out_en_d;
    logic        halt_q, halt_d;
    logic        mem_we;

    logic [1:0]  op;
    logic [2:0]  fa, fb;
    logic [3:0]  fn, dsh;
    logic [7:0]  d8;
    logic [15:0] ea, br_tgt;

    logic [15:0] alu_res;
    flags_t      alu_flags;
    logic        alu_wr, alu_upd;
    logic        cond_ok;

    assign op     = inst[15:14];
    assign fa     = inst[13:11];
    assign fb     = inst[10:8];
    assign fn     = inst[7:4];
    assign dsh    = inst[3:0];
    assign d8     = inst[7:0];
    assign ea     = regs_q[fb] + sext8(d8);
    assign br_tgt = pc_q + 16'd1 + sext8(d8);

    alu u_alu (
        .a_i      (regs_q[fb]),
        .b_i      (regs_q[fa]),
        .in_dat_i (in_dat),
        .f_i      (fn),
        .d_i      (dsh),
        .res_o    (alu_res),
        .flags_o  (alu_flags),
        .wr_o     (alu_wr),
        .upd_o    (alu_upd)
    );

    // Branch condition evaluation on current flags
    always_comb begin
        cond_ok = 1'b0;
        case (fb)
            CC_BE:   cond_ok = flags_q.z;
            CC_BLT:  cond_ok = flags_q.s ^ flags_q.v;
            CC_BLE:  cond_ok = flags_q.z | (flags_q.s ^ flags_q.v);
            CC_BNE:  cond_ok = !flags_q.z;
            default: cond_ok = 1'b0;
        endcase
    end

    // Next architectural state; everything holds once halted
    always_comb begin
        pc_d      = pc_q;
        regs_d    = regs_q;
        flags_d   = flags_q;
        out_dat_d = out_dat_q;
        out_en_d  = 1'b0;
        halt_d    = halt_q;
        mem_we    = 1'b0;
        if (!halt_q) begin
            pc_d = pc_q + 16'd1;
            case (op)
                OP_LD: regs_d[fa] = main_mem_dat;
                OP_ST: mem_we = 1'b1;
                OP_BR: begin
                    case (fa)
                        BR_LI:   regs_d[fb] = sext8(d8);
                        BR_B:    pc_d = br_tgt;
                        BR_BCC:  if (cond_ok) pc_d = br_tgt;
                        default: ;
                    endcase
                end
                OP_ALU: begin
                    if (alu_wr)  regs_d[fb] = alu_res;
                    if (alu_upd) flags_d = alu_flags;
                    if (fn == F_OUT) begin
                        out_en_d  = 1'b1;
                        out_dat_d = regs_q[fa];
                    end
                    if (fn == F_HLT) begin
                        halt_d = 1'b1;
                        pc_d   = pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q      <= '0;
            flags_q   <= '0;
            out_dat_q <= '0;
            out_en_q  <= 1'b0;
            halt_q    <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            pc_q      <= pc_d;
            flags_q   <= flags_d;
            out_dat_q <= out_dat_d;
            out_en_q  <= out_en_d;
            halt_q    <= halt_d;
            regs_q    <= regs_d;
        end
    end

    assign inst_mem_adr       = pc_q;
    assign main_mem_read_adr  = ea;
    assign main_mem_write     = mem_we & reset;
    assign main_mem_write_adr = ea;
    assign main_mem_write_dat = regs_q[fa];
    assign out_en             = out_en_q;
    assign out_dat            = out_dat_q;
    assign is_halt            = halt_q;

endmodule

// File: tb/tb_core.sv
// Directed bench for core: program table plus hand-written multi-cycle sequences.
module tb_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] inst_mem_adr, inst, rd_adr, mdat, wadr, wdat, in_dat, out_dat;
    logic        mwe, out_en, is_halt;

    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    logic [15:0] rom  [192];

    int ncmp = 0;
    int nerr = 0;
    int wp;

    core dut (
        .clk                (clk),
        .reset              (reset),
        .inst_mem_adr       (inst_mem_adr),
        .inst               (inst),
        .main_mem_read_adr  (rd_adr),
        .main_mem_dat       (mdat),
        .main_mem_write     (mwe),
        .main_mem_write_adr (wadr),
        .main_mem_write_dat (wdat),
        .in_dat             (in_dat),
        .out_en             (out_en),
        .out_dat            (out_dat),
        .is_halt            (is_halt)
    );

    always #5 clk = ~clk;

    assign inst = imem[inst_mem_adr[7:0]];
    assign mdat = dmem[rd_adr[7:0]];

    always @(posedge clk) if (mwe) dmem[wadr[7:0]] <= wdat;

    function automatic logic [15:0] A(input int rs, input int rd, input int f, input int d);
        return {2'b11, 3'(rs), 3'(rd), 4'(f), 4'(d)};
    endfunction
    function automatic logic [15:0] LI(input int rb, input int imm);
        return {2'b10, 3'b000, 3'(rb), 8'(imm)};
    endfunction
    function automatic logic [15:0] LD(input int ra, input int rb, input int off);
        return {2'b00, 3'(ra), 3'(rb), 8'(off)};
    endfunction
    function automatic logic [15:0] ST(input int ra, input int rb, input int off);
        return {2'b01, 3'(ra), 3'(rb), 8'(off)};
    endfunction
    function automatic logic [15:0] BCC(input int cc, input int off);
        return {2'b10, 3'b111, 3'(cc), 8'(off)};
    endfunction
    function automatic logic [15:0] BR(input int off);
        return {2'b10, 3'b100, 3'b000, 8'(off)};
    endfunction
    function automatic logic [15:0] HLT();
        return A(0, 0, 15, 0);
    endfunction

    task automatic put(input logic [15:0] w);
        rom[wp] = w;
        wp++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a program, clear data memory, apply one reset edge and check reset state
    task automatic load_reset(input int base, input logic [15:0] din);
        for (int i = 0; i < 256; i++) begin
            imem[i] = (i < 16) ? rom[base + i] : HLT();
            dmem[i] = '0;
        end
        in_dat = din;
        reset  = 1'b0;
        step();
        chk("rst_pc",   32'(inst_mem_adr), 32'h0);
        chk("rst_halt", 32'(is_halt), 32'h0);
        chk("rst_out",  32'({out_en, out_dat}), 32'h0);
        chk("rst_we",   32'(mwe), 32'h0);
        reset = 1'b1;
    endtask

    task automatic run_prog(input int base, input logic [15:0] din,
                            output int cnt, output logic [15:0] last, output logic halted);
        load_reset(base, din);
        cnt = 0; last = '0; halted = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (out_en) begin cnt++; last = out_dat; end
            if (is_halt) begin halted = 1'b1; break; end
        end
    endtask

    typedef struct {
        string       name;
        int          base;
        logic [15:0] din;
        logic [15:0] exp_out;
        int          exp_cnt;
        logic [3:0]  exp_flags;   // {S,Z,C,V}
    } vec_t;

    vec_t vt [11];

    initial begin
        int          cnt, subs, wcnt;
        logic [15:0] last, pc0;
        logic        halted, seen;

        in_dat = '0;
        for (int i = 0; i < 192; i++) rom[i] = HLT();

        wp = 0;   put(LI(1,5)); put(LI(2,-3)); put(A(2,1,0,0)); put(A(1,0,13,0));
        wp = 16;  put(LI(0,'h7F)); put(A(0,0,8,9)); put(A(0,0,11,15)); put(A(0,0,13,0));
        wp = 32;  put(LI(3,10)); put(ST(3,0,4)); put(LD(4,0,4)); put(A(4,0,13,0));
        wp = 48;  put(A(0,2,12,0)); put(A(2,0,13,0));
        wp = 64;  put(LI(1,1)); put(LI(2,'h80)); put(A(0,2,8,8)); put(A(1,2,1,0)); put(A(2,0,13,0));
        wp = 80;  put(LI(1,7)); put(LI(2,7)); put(A(2,1,5,0)); put(BCC(0,1)); put(LI(1,'h55)); put(A(1,0,13,0));
        wp = 96;  put(LI(1,'h81)); put(A(0,1,9,4)); put(A(0,1,10,1)); put(A(1,0,13,0));
        wp = 112; put(LI(1,'h10)); put(LI(2,3)); put(A(2,1,3,0)); put(A(1,3,6,0)); put(A(3,3,0,0)); put(A(3,0,13,0));
        wp = 128; put(LI(1,1)); put(LI(2,2)); put(A(2,1,5,0)); put(BCC(1,1)); put(LI(1,9)); put(BR(1)); put(LI(1,8)); put(A(1,0,13,0));
        wp = 144; put(LI(1,5)); put(LI(2,3)); put(A(2,1,5,0)); put(BCC(2,1)); put(A(1,0,13,0)); put(A(2,0,13,0));
        wp = 160; put(LI(5,1)); put(LI(1,3)); put(A(5,1,1,0)); put(BCC(3,-2)); put(A(1,0,13,0));

        vt[0]  = '{"add_carry",  0,   16'h0,    16'h0002, 1, 4'b0010};
        vt[1]  = '{"sll_sra",    16,  16'h0,    16'hFFFF, 1, 4'b1010};
        vt[2]  = '{"st_ld",      32,  16'h0,    16'h000A, 1, 4'b0000};
        vt[3]  = '{"in_out",     48,  16'h1234, 16'h1234, 1, 4'b0000};
        vt[4]  = '{"sub_ovf",    64,  16'h0,    16'h7FFF, 1, 4'b0001};
        vt[5]  = '{"cmp_be",     80,  16'h0,    16'h0007, 1, 4'b0100};
        vt[6]  = '{"rot_srl",    96,  16'h0,    16'h7C0F, 1, 4'b0010};
        vt[7]  = '{"or_mov_add", 112, 16'h0,    16'h0026, 1, 4'b0000};
        vt[8]  = '{"blt_b",      128, 16'h0,    16'h0001, 1, 4'b1010};
        vt[9]  = '{"ble_nt",     144, 16'h0,    16'h0003, 2, 4'b0000};
        vt[10] = '{"countdown",  160, 16'h0,    16'h0000, 1, 4'b0100};

        for (int k = 0; k < 11; k++) begin
            run_prog(vt[k].base, vt[k].din, cnt, last, halted);
            chk({vt[k].name, "_halt"},  32'(halted), 32'h1);
            chk({vt[k].name, "_out"},   32'(last), 32'(vt[k].exp_out));
            chk({vt[k].name, "_cnt"},   32'(cnt), 32'(vt[k].exp_cnt));
            chk({vt[k].name, "_flags"}, 32'(dut.flags_q), 32'(vt[k].exp_flags));
        end

        // Store pulse timing and registered OUT latency
        load_reset(32, 16'h0);
        wcnt = 0; seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (mwe) begin
                wcnt++;
                chk("st_adr", 32'(wadr), 32'h4);
                chk("st_dat", 32'(wdat), 32'hA);
            end
            if (out_en && !seen) begin
                seen = 1'b1;
                chk("out_lat_pc", 32'(inst_mem_adr), 32'h4);
            end
        end
        chk("st_pulses", 32'(wcnt), 32'h1);
        chk("st_mem", 32'(dmem[4]), 32'hA);
        chk("out_hold", 32'({out_en, out_dat}), 32'h0000A);

        // Countdown loop, then frozen state while halted
        load_reset(160, 16'h0);
        subs = 0; halted = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (is_halt) begin halted = 1'b1; break; end
            if (inst_mem_adr == 16'd2) subs++;
        end
        chk("loop_iters", 32'(subs), 32'h3);
        chk("loop_halt", 32'(halted), 32'h1);
        pc0 = inst_mem_adr;
        repeat (5) step();
        chk("halt_pc", 32'(inst_mem_adr), 32'(pc0));
        chk("halt_sig", 32'({is_halt, out_en, mwe}), 32'b100);

        // Reset while halted restarts from address 0
        reset = 1'b0;
        step();
        chk("rehalt_clr", 32'(is_halt), 32'h0);
        chk("rehalt_pc", 32'(inst_mem_adr), 32'h0);
        reset = 1'b1;
        subs = 0; halted = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (is_halt) begin halted = 1'b1; break; end
            if (inst_mem_adr == 16'd2) subs++;
        end
        chk("rerun_iters", 32'(subs), 32'h3);
        chk("rerun_halt", 32'(halted), 32'h1);

        // Store at PC 0 must be suppressed while reset is held
        for (int i = 0; i < 256; i++) imem[i] = HLT();
        imem[0] = ST(0, 0, 8);
        reset = 1'b0;
        step();
        chk("rst_force_we", 32'(mwe), 32'h0);
        reset = 1'b1;
        #1;
        chk("rel_we", 32'(mwe), 32'h1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/core.md
CORE -- requirements
Module: core

Interface
REQ-001 SHALL have no parameters; the datapath is fixed at 16 bits.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  system clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-low reset (0 = reset).
REQ-005 inst_mem_adr  out  16  word address of instruction = PC.
REQ-006 inst  in  16  instruction word, combinational read of inst_mem_adr.
REQ-007 main_mem_read_adr  out  16  data load address.
REQ-008 main_mem_dat  in  16  data word, combinational read of main_mem_read_adr.
REQ-009 main_mem_write  out  1  store enable; memory writes on the next rising clk.
REQ-010 main_mem_write_adr / main_mem_write_dat  out  16 each  store address / data.
REQ-011 in_dat  in  16  external input port.
REQ-012 out_en / out_dat  out  1 / 16  output strobe / output data.
REQ-013 is_halt  out  1  high once HLT has executed.

Function
REQ-014 SHALL execute one instruction per cycle: fetch, execute and writeback all complete in one clk.
REQ-015 Architectural state: 8x16 registers r0-r7, 16-bit PC, and flags S, Z, C, V.
REQ-016 op=inst[15:14]=11 (ALU): rs=[13:11], rd=[10:8], f=[7:4], d=[3:0].
- f=0 ADD rd+=rs; 1 SUB rd-=rs; 2 AND; 3 OR; 4 XOR; 5 CMP (flags of rd-rs, no write); 6 MOV rd=rs.
- f=8 SLL rd<<d; 9 SLR rotate-left by d; 10 SRL logical >>d; 11 SRA arithmetic >>d.
- f=12 IN rd=in_dat; 13 OUT; 15 HLT.
- Any other f is a NOP that still increments PC.
REQ-017 Flag rules: S=result[15], Z=(result==0).
- ADD: C=carry-out; V=signed overflow.
- SUB/CMP: C=unsigned borrow; V=signed overflow.
- Logic/MOV/IN: C=V=0.
- Shifts: C=last bit shifted out (0 when d=0); V=0.
- OUT, HLT, LD, ST, LI and branches leave flags unchanged.
REQ-018 op=00 LD: ra=[13:11], rb=[10:8], d8=[7:0]; main_mem_read_adr=rb+sext(d8); ra<=main_mem_dat.
REQ-019 op=01 ST: main_mem_write=1, main_mem_write_adr=rb+sext(d8), main_mem_write_dat=ra, in the same cycle.
- main_mem_write SHALL be 0 for every other instruction.
REQ-020 op=10, [13:11]=000 LI: rb<=sext(d8).
REQ-021 op=10, [13:11]=100 B: PC<=PC+1+sext(d8).
REQ-022 op=10, [13:11]=111 Bcc: cond=[10:8].
- 000 BE (Z); 001 BLT (S^V); 010 BLE (Z|(S^V)); 011 BNE (!Z).
- When cond holds, PC<=PC+1+sext(d8); otherwise, and for any other cond, PC<=PC+1.
REQ-023 Any other op=10 encoding is a NOP.
REQ-024 All 16-bit additions wrap modulo 2^16, including the PC.
REQ-025 OUT: out_dat<=rs and out_en<=1, both registered, so visible the cycle after OUT; out_en is a one-cycle pulse.
- out_dat SHALL hold its value between OUTs.
REQ-026 HLT: is_halt<=1; PC, registers, flags and memory SHALL then freeze until reset.
- While halted, main_mem_write=0 and out_en=0.
REQ-027 Writing rd when rd=rs uses the pre-instruction value of rs.

Reset
REQ-028 On a rising clk with reset=0: PC, r0-r7, flags, out_dat = 0; out_en = 0; is_halt = 0.
REQ-029 While reset=0, main_mem_write SHALL be forced to 0.
REQ-030 Reset SHALL override HLT and any in-flight instruction; execution resumes at address 0 on the first edge after reset returns to 1.

Structure
REQ-031 A shared package core_pkg SHALL hold the opcode, ALU-function and branch-condition constants and a flags struct typedef.
REQ-032 A single sub-module alu (operands, f, d -> result, flags) is natural; the register file and decode stay in core.

Verification
REQ-033 Write LI r1,5; LI r2,-3; ADD r1,r2; OUT r1 -> out_en pulses once, out_dat=0x0002; flags C=1, Z=0, S=0, V=0.
REQ-034 Write LI r0,0x7F; SLL r0,9; SRA r0,15; OUT r0 -> out_dat=0xFFFF.
REQ-035 Write LI r3,10; ST r3,4(r0); LD r4,4(r0); OUT r4 -> main_mem_write high for one cycle at address 4, data 10; out_dat=0x000A.
REQ-036 Write a countdown loop: LI r1,3; SUB r1,r5 (r5=1); BNE -2; then HLT -> exactly 3 loop iterations; is_halt=1 and PC stays constant afterwards.
REQ-037 Drive in_dat=0x1234; run IN r2; OUT r2 -> out_dat=0x1234.
REQ-038 Assert reset=0 while halted -> next edge is_halt=0, PC=0, and the program re-executes.
